// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, instruction field positions and sequencer states.
// Imported by both the control unit and the ALU so the opcode map lives in one place.
package cpu_pkg;

    localparam int OPCODE_MSB  = 11;
    localparam int OPCODE_LSB  = 8;
    localparam int OPERAND_MSB = 7;
    localparam int OPERAND_LSB = 0;

    localparam logic [3:0] OP_LOAD = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_JZ   = 4'd9;
    localparam logic [3:0] OP_NOP  = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

    // Opcodes 0..7 are the only ones the ALU acts on.
    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Bus between the control unit and its ROM / ALU neighbours.
// master = control unit side, slave = ROM/ALU/environment side.
interface unidade_controle_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 12
);
    logic                 run;
    logic [INSTR_W-1:0]   rom_data;
    logic                 acc_zero;
    logic                 rom_en;
    logic [PC_W-1:0]      rom_addr;
    logic [PC_W-1:0]      pc;
    logic [3:0]           opcode;
    logic [INSTR_W-5:0]   operando;
    logic                 ula_en;
    logic                 halted;

    modport master (
        input  run, rom_data, acc_zero,
        output rom_en, rom_addr, pc, opcode, operando, ula_en, halted
    );

    modport slave (
        output run, rom_data, acc_zero,
        input  rom_en, rom_addr, pc, opcode, operando, ula_en, halted
    );

endinterface

// File: rtl/unidade_controle_contador_programa.sv
// Program counter register: synchronous reset, parallel load for jumps,
// and increment that wraps naturally at the register width.
module contador_programa #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] load_value,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst)
            pc <= '0;
        else if (load)
            pc <= load_value;
        else if (inc)
            pc <= pc + 1'b1;
    end

endmodule

// File: rtl/unidade_controle.sv
// Fetch/decode/execute sequencer in front of the ALU: one instruction every
// three cycles, with JMP/JZ handling and a sticky HALT.
module unidade_controle
    import cpu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    unidade_controle_if.master  bus
);

    localparam logic [1:0] S_FETCH  = FETCH;
    localparam logic [1:0] S_DECODE = DECODE;
    localparam logic [1:0] S_EXEC   = EXEC;
    localparam logic [1:0] S_HALT   = HALT;

    logic [1:0]          state;
    logic [1:0]          next_state;
    logic [3:0]          opcode;
    logic [INSTR_W-5:0]  operando;
    logic [PC_W-1:0]     pc;
    logic                pc_load;
    logic                pc_inc;

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  next_state = bus.run ? S_DECODE : S_FETCH;
            S_DECODE: next_state = S_EXEC;
            S_EXEC:   next_state = (opcode == OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            opcode   <= '0;
            operando <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                opcode   <= bus.rom_data[OPCODE_MSB:OPCODE_LSB];
                operando <= bus.rom_data[OPERAND_MSB:OPERAND_LSB];
            end
        end
    end

    // acc_zero only matters on the EXEC edge of a JZ; HALT leaves pc untouched.
    always_comb begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        if (state == S_EXEC) begin
            pc_load = (opcode == OP_JMP) || ((opcode == OP_JZ) && bus.acc_zero);
            pc_inc  = !pc_load && (opcode != OP_HALT);
        end
    end

    contador_programa #(
        .PC_W(PC_W)
    ) u_contador_programa (
        .clk        (clk),
        .rst        (rst),
        .load       (pc_load),
        .load_value (PC_W'(operando)),
        .inc        (pc_inc),
        .pc         (pc)
    );

    // rom_en is gated by rst so a held reset never issues a ROM read.
    assign bus.rom_en   = (state == S_FETCH) && bus.run && !rst;
    assign bus.rom_addr = pc;
    assign bus.pc       = pc;
    assign bus.opcode   = opcode;
    assign bus.operando = operando;
    assign bus.ula_en   = (state == S_EXEC) && is_alu_op(opcode);
    assign bus.halted   = (state == S_HALT);

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed scenarios followed by
// random programs, checked against an instruction-level reference model.
module tb_unidade_controle;

    logic clk = 1'b0;
    logic rst;

    unidade_controle_if #(.PC_W(8), .INSTR_W(12)) ctrl ();

    unidade_controle #(.PC_W(8), .INSTR_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ctrl.master)
    );

    always #5 clk = ~clk;

    logic [11:0] rom [256];
    always @(posedge clk) begin
        if (ctrl.rom_en)
            ctrl.rom_data <= rom[ctrl.rom_addr];
    end

    int total = 0;
    int bad   = 0;

    logic [7:0] model_pc;
    logic [3:0] model_opcode;
    logic [7:0] model_operando;
    logic       model_halted;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, " pc"},       32'(ctrl.pc),       32'h0);
        checkOutput({tag, " opcode"},   32'(ctrl.opcode),   32'h0);
        checkOutput({tag, " operando"}, 32'(ctrl.operando), 32'h0);
        checkOutput({tag, " rom_en"},   32'(ctrl.rom_en),   32'h0);
        checkOutput({tag, " ula_en"},   32'(ctrl.ula_en),   32'h0);
        checkOutput({tag, " halted"},   32'(ctrl.halted),   32'h0);
    endtask

    // Holds rst for two cycles with run randomly high (reset must win).
    task automatic reset_dut();
        rst = 1'b1;
        ctrl.run = 1'($urandom);
        #1 checkOutput("rom_en during rst", 32'(ctrl.rom_en), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1 check_reset_values("reset");
        rst = 1'b0;
        ctrl.run = 1'b0;
        model_pc = 8'h0;
        model_opcode = 4'h0;
        model_operando = 8'h0;
        model_halted = 1'b0;
    endtask

    // Runs one instruction from model_pc; starts and ends at a FETCH-cycle negedge.
    task automatic applyStimulus(input int idle, input logic az);
        logic [11:0] instr;
        logic [3:0]  op;
        logic [7:0]  opd;
        logic [7:0]  next_pc;
        ctrl.run = 1'b0;
        for (int i = 0; i < idle; i++) begin
            #1 checkOutput("idle rom_en", 32'(ctrl.rom_en), 32'h0);
            checkOutput("idle pc", 32'(ctrl.pc), 32'(model_pc));
            @(negedge clk);
        end
        ctrl.run = 1'b1;
        #1 checkOutput("fetch rom_en", 32'(ctrl.rom_en), 32'h1);
        checkOutput("fetch rom_addr", 32'(ctrl.rom_addr), 32'(model_pc));
        checkOutput("fetch ula_en", 32'(ctrl.ula_en), 32'h0);
        instr = rom[model_pc];
        op = instr[11:8];
        opd = instr[7:0];

        @(negedge clk);
        ctrl.run = 1'($urandom);
        #1 checkOutput("decode rom_en", 32'(ctrl.rom_en), 32'h0);
        checkOutput("decode ula_en", 32'(ctrl.ula_en), 32'h0);
        checkOutput("decode opcode hold", 32'(ctrl.opcode), 32'(model_opcode));

        @(negedge clk);
        ctrl.acc_zero = az;
        model_opcode = op;
        model_operando = opd;
        #1 checkOutput("exec ula_en", 32'(ctrl.ula_en), 32'(op < 4'd8));
        checkOutput("exec opcode", 32'(ctrl.opcode), 32'(op));
        checkOutput("exec operando", 32'(ctrl.operando), 32'(opd));
        checkOutput("exec pc", 32'(ctrl.pc), 32'(model_pc));
        checkOutput("exec rom_en", 32'(ctrl.rom_en), 32'h0);

        if (op == 4'd15) next_pc = model_pc;
        else if (op == 4'd8) next_pc = opd;
        else if (op == 4'd9 && az) next_pc = opd;
        else next_pc = 8'((int'(model_pc) + 1) % 256);
        model_pc = next_pc;

        @(negedge clk);
        if (op == 4'd15) begin
            model_halted = 1'b1;
            ctrl.run = 1'b1;
            for (int i = 0; i < 5; i++) begin
                #1 checkOutput("halt halted", 32'(ctrl.halted), 32'h1);
                checkOutput("halt rom_en", 32'(ctrl.rom_en), 32'h0);
                checkOutput("halt pc", 32'(ctrl.pc), 32'(model_pc));
                checkOutput("halt ula_en", 32'(ctrl.ula_en), 32'h0);
                @(negedge clk);
            end
        end else begin
            ctrl.run = 1'b0;
            #1 checkOutput("next pc", 32'(ctrl.pc), 32'(model_pc));
            checkOutput("after ula_en", 32'(ctrl.ula_en), 32'h0);
            checkOutput("after halted", 32'(ctrl.halted), 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1;
        ctrl.run = 1'b0;
        ctrl.acc_zero = 1'b0;
        for (int a = 0; a < 256; a++) rom[a] = 12'hA00;
        @(negedge clk);

        $display("[TB] scenario: reset, ALU op, halt");
        rom[0] = 12'h105;
        rom[1] = 12'h2AA;
        rom[2] = 12'hF00;
        reset_dut();
        applyStimulus(0, 1'b0);
        applyStimulus(1, 1'b0);
        applyStimulus(0, 1'b1);
        checkOutput("halt pc stays 2", 32'(ctrl.pc), 32'h2);
        reset_dut();

        $display("[TB] scenario: jumps and wrap");
        for (int a = 0; a < 256; a++) rom[a] = 12'hA00;
        rom[0]    = 12'h820;
        rom[8'h20] = 12'h803;
        rom[3]    = 12'h910;
        rom[8'h10] = 12'h803;
        rom[4]    = 12'h8FF;
        rom[8'hFF] = 12'hA00;
        applyStimulus(0, 1'b1);
        checkOutput("jmp target", 32'(ctrl.pc), 32'h20);
        applyStimulus(0, 1'b0);
        applyStimulus(0, 1'b1);
        checkOutput("jz taken", 32'(ctrl.pc), 32'h10);
        applyStimulus(0, 1'b0);
        applyStimulus(0, 1'b0);
        checkOutput("jz not taken", 32'(ctrl.pc), 32'h4);
        applyStimulus(0, 1'b0);
        applyStimulus(0, 1'b0);
        checkOutput("pc wrap", 32'(ctrl.pc), 32'h0);

        $display("[TB] scenario: run gating and mid-op reset");
        for (int a = 0; a < 256; a++) rom[a] = 12'hA00;
        rom[0] = 12'h105;
        rom[1] = 12'h333;
        reset_dut();
        applyStimulus(10, 1'b0);
        ctrl.run = 1'b1;
        #1 checkOutput("midrst fetch rom_en", 32'(ctrl.rom_en), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 check_reset_values("midrst");
        rst = 1'b0;
        ctrl.run = 1'b0;
        model_pc = 8'h0;
        model_opcode = 4'h0;
        model_operando = 8'h0;
        model_halted = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 checkOutput("midrst no ula_en", 32'(ctrl.ula_en), 32'h0);
        end
        checkOutput("midrst pc", 32'(ctrl.pc), 32'h0);

        $display("[TB] scenario: random programs");
        for (int a = 0; a < 256; a++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'd15 && $urandom_range(0, 7) != 0) op = 4'd1;
            rom[a] = {op, 8'($urandom)};
        end
        reset_dut();
        for (int n = 0; n < 200; n++) begin
            applyStimulus($urandom_range(0, 2), 1'($urandom));
            if (model_halted) reset_dut();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle fetch/decode/execute sequencer that sits directly upstream of the CPU ALU. It fetches 12-bit instructions from a synchronous program ROM and splits each into a 4-bit opcode and an 8-bit operand. It presents them to the ALU with a one-cycle execute strobe and handles the program counter, jumps and halt. One instruction completes every 3 cycles.

## Interface
Parameters:
- `PC_W`, 8: program counter / ROM address width.
- `INSTR_W`, 12: instruction width, opcode in [11:8], operand in [7:0].

Ports:
- `clk`  in  1  sole clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  1 = sequencer may start a new fetch; 0 = park in FETCH.
- `rom_data`  in  12  ROM read data, valid the cycle after `rom_en`.
- `acc_zero`  in  1  accumulator-equals-zero flag from the ALU/accumulator side.
- `rom_en`  out  1  ROM read enable.
- `rom_addr`  out  8  ROM address, always equals `pc`.
- `pc`  out  8  program counter.
- `opcode`  out  4  latched opcode to ALU.
- `operando`  out  8  latched operand to ALU.
- `ula_en`  out  1  one-cycle strobe: ALU executes `opcode`/`operando`.
- `halted`  out  1  1 while in HALT.

## Operation
- Opcodes 0–7 are ALU ops: 0 load, 1 add, 2 sub, 3 mul, 4 div, 5 and, 6 or, 7 xor. They are passed through unchanged and strobe `ula_en`.
- Opcode 8 is JMP: `pc <= operand`.
- Opcode 9 is JZ: `pc <= operand` if `acc_zero`==1 sampled in EXEC, otherwise `pc+1`.
- Opcode 10 is NOP. Opcodes 11–14 are reserved and execute as NOP.
- Opcode 15 is HALT.
- FSM states:
  - FETCH: if `run`, assert `rom_en` with `rom_addr=pc` and go to DECODE. Otherwise stay in FETCH with `rom_en=0`.
  - DECODE: latch `rom_data[11:8]` into `opcode` and `rom_data[7:0]` into `operando`, then go to EXEC.
  - EXEC: for ALU ops assert `ula_en`. Update `pc` (jump target or `pc+1`, modulo 256) and go to FETCH. For HALT, do not change `pc` and go to HALT.
  - HALT: sticky. Only `rst` leaves it. `run` is ignored.
- `opcode`/`operando` hold their last latched values until the next DECODE. The ALU may sample them any time `ula_en`=1.
- `pc` wraps 255 → 0 on increment.
- JMP/JZ never strobe `ula_en`.
- `run` is sampled only in FETCH. Dropping `run` mid-instruction does not abort that instruction.

## Timing
- Reset values: state FETCH, `pc`=0, `opcode`=0, `operando`=0, `rom_en`=0, `ula_en`=0, `halted`=0.
- Instruction latency is 3 cycles:
  - cycle N: FETCH (`rom_en`=1).
  - cycle N+1: DECODE (`rom_data` captured).
  - cycle N+2: EXEC (`ula_en` high for exactly this cycle; new `pc` visible at N+3).
- With `run` held at 1, `rom_en` pulses every third cycle.
- `halted` rises in the cycle after EXEC of HALT.
- `rst` asserted in any state returns all outputs to reset values on the next edge, overriding any pending pc update or strobe.
- `rst` and `run` high together: reset wins. The first fetch happens on the first edge with `rst`=0 and `run`=1.
- `acc_zero` is sampled only at the EXEC edge of JZ. The upstream accumulator must be settled by then, which covers back-to-back ALU op then JZ.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants `OP_LOAD` … `OP_XOR`, `OP_JMP`, `OP_JZ`, `OP_NOP`, `OP_HALT`;
  - state enum `{FETCH, DECODE, EXEC, HALT}`;
  - field positions for opcode and operand.
- The ALU imports the same opcode constants.
- Natural sub-module: `contador_programa`, holding the PC register with reset, load (jump) and increment enable, and modulo wrap.
- The FSM and instruction latch stay in `unidade_controle`.

## Test plan
- Reset and run: reset, `run`=1, ROM[0]=0x105 → `rom_en` at cycle 0; at cycle 2 `ula_en`=1, `opcode`=1, `operando`=5; then `pc`=1.
- Jump: ROM[0]=0x820 → no `ula_en`; `pc`=0x20; next `rom_addr`=0x20.
- Conditional jump: ROM[3]=0x910. With `acc_zero`=1 → `pc`=0x10. With `acc_zero`=0 → `pc`=4.
- Wrap: force `pc`=255 via JMP 0xFF, ROM[255]=0xA00 → after EXEC `pc`=0.
- Halt: ROM[2]=0xF00 → `halted`=1, `pc` stays 2, no further `rom_en` with `run`=1. Then `rst` → `pc`=0 and `halted`=0.
- Run gating and mid-op reset:
  - `run`=0 → `rom_en` stays 0 for 10 cycles with `pc` unchanged.
  - `rst` asserted during DECODE → all outputs at reset values next cycle and no `ula_en` pulse.
